hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Pipeline hazard controller (branch flush, load-use stall,
//             multi-cycle EX stall, HALT) with a saturating stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REG_W        = 3,
    parameter int MULTI_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [REG_W-1:0] ID_ra,
    input  logic [REG_W-1:0] ID_rb,
    input  logic             ID_uses_ra,
    input  logic             ID_uses_rb,
    input  logic             ID_halt,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_mem_read,
    input  logic             EX_reg_write,
    input  logic             EX_branch_taken,
    input  logic             EX_multi_start,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             halted,
    output logic [15:0]      stall_count
);

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        MULTI = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              load_use;

    assign load_use = EX_mem_read & EX_reg_write &
                      ((ID_uses_ra & (ID_ra == EX_rd)) |
                       (ID_uses_rb & (ID_rb == EX_rd)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_cnt_d  = stall_cnt_q;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        halted       = 1'b0;

        case (state_q)
            IDLE: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (EX_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (EX_multi_start) begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = MULTI;
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end else if (ID_halt) begin
                    state_d = HALT;
                end
            end
            MULTI: begin
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_stall   = 1'b1;
                exmem_bubble = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HALT: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only pipeline-active states contribute to the stall statistic.
        if (((state_q == RUN) || (state_q == MULTI)) && pc_stall &&
            (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        // While reset is held the pipeline sees the IDLE control pattern.
        if (!reset) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            ifid_flush   = 1'b0;
            idex_stall   = 1'b0;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b0;
            halted       = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Scoreboard bench for hazard_ctrl using directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        reset, start;
    logic [2:0]  ID_ra, ID_rb, EX_rd;
    logic        ID_uses_ra, ID_uses_rb, ID_halt;
    logic        EX_mem_read, EX_reg_write, EX_branch_taken, EX_multi_start;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic        exmem_bubble, halted;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fails  = 0;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble, halted}
    localparam logic [6:0] C_IDLE  = 7'b1100100;
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_BR    = 7'b0010100;
    localparam logic [6:0] C_MULTI = 7'b1101010;
    localparam logic [6:0] C_LU    = 7'b1100100;
    localparam logic [6:0] C_HALT  = 7'b1100101;

    typedef struct packed {
        logic        chk;
        int          id;
        logic [6:0]  ctl;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   step_id = 0;

    hazard_ctrl #(.REG_W(3), .MULTI_CYCLES(4)) dut (
        .CLK(CLK), .reset(reset), .start(start),
        .ID_ra(ID_ra), .ID_rb(ID_rb), .ID_uses_ra(ID_uses_ra), .ID_uses_rb(ID_uses_rb),
        .ID_halt(ID_halt), .EX_rd(EX_rd), .EX_mem_read(EX_mem_read),
        .EX_reg_write(EX_reg_write), .EX_branch_taken(EX_branch_taken),
        .EX_multi_start(EX_multi_start), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
        .exmem_bubble(exmem_bubble), .halted(halted), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = exp_q.pop_front();
            act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                   exmem_bubble, halted};
            if (e.chk) begin
                n_checks++;
                if (act !== e.ctl) begin
                    n_fails++;
                    $display("FAIL ctl@step%0d: got %b expected %b", e.id, act, e.ctl);
                end
                n_checks++;
                if (stall_count !== e.sc) begin
                    n_fails++;
                    $display("FAIL stall_count@step%0d: got %h expected %h",
                             e.id, stall_count, e.sc);
                end
            end
        end
    end

    // One cycle of stimulus: drive inputs just after the edge, queue expectation.
    task automatic apply(input logic rst, input logic st, input logic bt, input logic ms,
                         input logic mr, input logic rw, input logic [2:0] rd,
                         input logic [2:0] ra, input logic ua, input logic [2:0] rb,
                         input logic ub, input logic hl, input logic [6:0] ctl,
                         input logic [15:0] sc, input logic chk);
        exp_t e;
        @(posedge CLK);
        #1;
        reset = rst; start = st; EX_branch_taken = bt; EX_multi_start = ms;
        EX_mem_read = mr; EX_reg_write = rw; EX_rd = rd;
        ID_ra = ra; ID_uses_ra = ua; ID_rb = rb; ID_uses_rb = ub; ID_halt = hl;
        step_id++;
        e.chk = chk; e.id = step_id; e.ctl = ctl; e.sc = sc;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; ID_ra = '0; ID_rb = '0; EX_rd = '0;
        ID_uses_ra = 1'b0; ID_uses_rb = 1'b0; ID_halt = 1'b0;
        EX_mem_read = 1'b0; EX_reg_write = 1'b0; EX_branch_taken = 1'b0;
        EX_multi_start = 1'b0;
        repeat (2) @(posedge CLK);

        //     rst st bt ms mr rw rd ra ua rb ub hl ctl      sc
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  16'd0, 1);
        apply(1, 1, 0, 0, 0, 1, 3, 3, 1, 0, 0, 0, C_NONE,  16'd0, 1);
        apply(1, 0, 0, 0, 1, 1, 3, 3, 1, 0, 0, 0, C_LU,    16'd0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  16'd1, 1);
        apply(1, 0, 1, 0, 1, 1, 5, 0, 0, 5, 1, 0, C_BR,    16'd1, 1);
        apply(1, 0, 0, 0, 1, 0, 5, 0, 0, 5, 1, 0, C_NONE,  16'd1, 1);
        apply(1, 0, 0, 0, 1, 1, 5, 0, 0, 5, 1, 0, C_LU,    16'd1, 1);
        apply(1, 0, 0, 1, 1, 1, 5, 0, 0, 5, 1, 0, C_MULTI, 16'd2, 1);
        apply(1, 1, 1, 1, 1, 1, 2, 2, 1, 0, 0, 1, C_MULTI, 16'd3, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_MULTI, 16'd4, 1);
        apply(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MULTI, 16'd5, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  16'd6, 1);
        // reset asserted on the second MULTI cycle
        apply(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MULTI, 16'd6, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MULTI, 16'd7, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd8, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        // HALT entry and exit
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE,  16'd0, 1);
        apply(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, C_HALT,  16'd0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_HALT,  16'd0, 1);
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        // Saturation: continuous load-use stalls well past 16'hFFFF
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE,  16'd0, 1);
        for (int i = 0; i < 65540; i++) begin
            logic [15:0] sc_e;
            logic        ck;
            sc_e = (i >= 65535) ? 16'hFFFF : 16'(i);
            ck   = (i == 0) || (i == 65534) || (i == 65535) || (i == 65539);
            apply(1, 0, 0, 0, 1, 1, 6, 6, 1, 0, 0, 0, C_LU, sc_e, ck);
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  16'hFFFF, 1);

        repeat (3) @(posedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
